// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and defaults for the shift-and-add multiplier dispatcher.
//   disp_state_t : dispatcher FSM state encoding (IDLE, ISSUE, WAIT)
//   TAMANO_DEF   : default operand width
//   DEPTH_DEF    : default operand FIFO depth
//   TIMEOUT_DEF  : default watchdog limit in WAIT cycles
//   wd_width()   : watchdog counter width for a given timeout
// The operand-pair struct depends on the operand width, so it is declared
// inside the modules that know that width.
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } disp_state_t;

    localparam int TAMANO_DEF  = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    // Counter width able to hold 0 .. timeout-1 (at least one bit).
    function automatic int wd_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mult_fifo.sv
// -----------------------------------------------------------------------------
// mult_fifo
// Synchronous FIFO with a registered read port.
//   CLOCK   in  : clock, rising edge
//   RESET   in  : asynchronous, active-high; empties the FIFO
//   push    in  : write wr_data (ignored when full)
//   wr_data in  : WIDTH-bit write data
//   pop     in  : read head into rd_data (ignored when empty)
//   rd_data out : head entry, valid the cycle after an accepted pop
//   full    out : DEPTH entries stored
//   empty   out : no entries stored
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module mult_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, and a reset-free array maps onto plain RAM.
    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mult_dispatcher.sv
// -----------------------------------------------------------------------------
// mult_dispatcher
// Feeds operand pairs to the shift-and-add multiplier and collects products.
//   CLOCK, RESET         : clock / async active-high reset (shared with multiplier)
//   IN_VALID/IN_READY    : operand stream handshake (IN_READY = !fifo full)
//   IN_A, IN_B           : multiplicand / multiplier
//   OUT_VALID/OUT_READY  : result stream handshake
//   OUT_S                : product (0 on timeout)
//   OUT_ERR              : result is a watchdog timeout
//   START                : one-cycle start pulse to the multiplier
//   A, B                 : operands to the multiplier, held from ISSUE through WAIT
//   S, END_MULT          : product and done flag from the multiplier
//   BUSY                 : FSM not in IDLE
// One multiplication is outstanding at a time; results leave in arrival order.
// -----------------------------------------------------------------------------
module mult_dispatcher
    import mult_pkg::*;
#(
    parameter int tamano  = TAMANO_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [tamano-1:0]   IN_A,
    input  logic [tamano-1:0]   IN_B,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [2*tamano-1:0] OUT_S,
    output logic                OUT_ERR,
    output logic                START,
    output logic [tamano-1:0]   A,
    output logic [tamano-1:0]   B,
    input  logic [2*tamano-1:0] S,
    input  logic                END_MULT,
    output logic                BUSY
);

    typedef struct packed {
        logic [tamano-1:0] a;
        logic [tamano-1:0] b;
    } operand_t;

    localparam int                WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    disp_state_t     state;
    disp_state_t     state_nxt;
    operand_t        wr_pair;
    operand_t        rd_pair;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            fetch;      // pop issued last cycle; rd_pair is now valid
    logic            load_op;
    logic            res_ok;
    logic            res_timeout;
    logic [WD_W-1:0] watchdog;

    assign wr_pair  = '{a: IN_A, b: IN_B};
    assign IN_READY = !fifo_full;
    assign BUSY     = (state != IDLE);

    mult_fifo #(
        .WIDTH (2*tamano),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .push    (IN_VALID && IN_READY),
        .wr_data (wr_pair),
        .pop     (fifo_pop),
        .rd_data (rd_pair),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        fifo_pop    = 1'b0;
        load_op     = 1'b0;
        res_ok      = 1'b0;
        res_timeout = 1'b0;
        START       = 1'b0;
        unique case (state)
            IDLE: begin
                // The FIFO read is registered: pop in one cycle, load A/B
                // from its output register in the next.
                if (fetch) begin
                    load_op   = 1'b1;
                    state_nxt = ISSUE;
                end else if (!fifo_empty && !OUT_VALID) begin
                    fifo_pop = 1'b1;
                end
            end
            ISSUE: begin
                START     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion on the last allowed cycle still counts as a product.
                if (END_MULT) begin
                    res_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (watchdog == WD_LAST) begin
                    res_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fetch     <= 1'b0;
            A         <= '0;
            B         <= '0;
            watchdog  <= '0;
            OUT_VALID <= 1'b0;
            OUT_S     <= '0;
            OUT_ERR   <= 1'b0;
        end else begin
            fetch <= fifo_pop;

            if (load_op) begin
                A        <= rd_pair.a;
                B        <= rd_pair.b;
                watchdog <= '0;
            end else if (state == WAIT) begin
                watchdog <= watchdog + WD_W'(1);
            end

            // A new result can only arrive while the slot is empty, because
            // a pop is held off until the previous result has drained.
            if (res_ok) begin
                OUT_S     <= S;
                OUT_ERR   <= 1'b0;
                OUT_VALID <= 1'b1;
            end else if (res_timeout) begin
                OUT_S     <= '0;
                OUT_ERR   <= 1'b1;
                OUT_VALID <= 1'b1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_mult_dispatcher
// Directed bench for mult_dispatcher with a behavioural multiplier stub.
// The stub raises END_MULT stub_delay cycles after it sees START (holding the
// level until the next START) or never, when stub_hang was set at START time.
// -----------------------------------------------------------------------------
module tb_mult_dispatcher;

    localparam int TW  = 8;
    localparam int DP  = 4;
    localparam int TO  = 64;
    localparam int DLY = 17;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic              IN_VALID;
    logic              IN_READY;
    logic [TW-1:0]     IN_A;
    logic [TW-1:0]     IN_B;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [2*TW-1:0]   OUT_S;
    logic              OUT_ERR;
    logic              START;
    logic [TW-1:0]     A;
    logic [TW-1:0]     B;
    logic [2*TW-1:0]   S;
    logic              END_MULT;
    logic              BUSY;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                start_count = 0;
    logic [2*TW:0]     sb [$];   // {err, product}

    int                stub_delay = DLY;
    logic              stub_hang  = 1'b0;
    logic              m_run;
    logic              m_hang;
    int                m_cnt;

    always #5 CLOCK = ~CLOCK;

    mult_dispatcher #(
        .tamano  (TW),
        .DEPTH   (DP),
        .TIMEOUT (TO)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_S     (OUT_S),
        .OUT_ERR   (OUT_ERR),
        .START     (START),
        .A         (A),
        .B         (B),
        .S         (S),
        .END_MULT  (END_MULT),
        .BUSY      (BUSY)
    );

    // Multiplier stub.
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            END_MULT <= 1'b0;
            S        <= '0;
            m_run    <= 1'b0;
            m_hang   <= 1'b0;
            m_cnt    <= 0;
        end else if (START) begin
            END_MULT <= 1'b0;
            m_run    <= 1'b1;
            m_hang   <= stub_hang;
            m_cnt    <= 0;
        end else if (m_run && !m_hang) begin
            if (m_cnt + 1 == stub_delay) begin
                END_MULT <= 1'b1;
                S        <= 16'(A) * 16'(B);
                m_run    <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are checked 1 ns after the rising edge.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic sig(input int sel);
        return (sel == 0) ? START : OUT_VALID;
    endfunction

    // Steps until START (sel=0) or OUT_VALID (sel=1) is high; n = steps taken.
    task automatic wait_for(input string tag, input int sel, input int max, output int n);
        n = 0;
        while (sig(sel) !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check(tag, {31'b0, sig(sel)}, 32'd1);
    endtask

    task automatic push(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic err);
        int n;
        IN_VALID = 1'b1;
        IN_A     = a;
        IN_B     = b;
        n = 0;
        while (IN_READY !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("push_ready", {31'b0, IN_READY}, 32'd1);
        if (IN_READY === 1'b1) sb.push_back(err ? {1'b1, 16'd0} : {1'b0, 16'(a) * 16'(b)});
        step();
        IN_VALID = 1'b0;
    endtask

    always @(negedge CLOCK) begin
        if (START === 1'b1) start_count++;
    end

    // Scoreboard: compare every result handed over at the coming edge.
    always @(negedge CLOCK) begin
        logic [2*TW:0] e;
        if (RESET === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            // {err=1, S=FFFF} never occurs, so an unexpected result always fails.
            e = (sb.size() > 0) ? sb.pop_front() : {1'b1, 16'hFFFF};
            check("result", {15'b0, OUT_ERR, OUT_S}, {15'b0, e});
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        int n;
        int sc;
        logic [TW-1:0] ba [5];
        logic [TW-1:0] bb [5];
        ba = '{8'd1, 8'd255, 8'd0, 8'd16, 8'd100};
        bb = '{8'd1, 8'd255, 8'd77, 8'd16, 8'd200};

        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_A      = '0;
        IN_B      = '0;
        OUT_READY = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_in_ready",  {31'b0, IN_READY},  32'd1);
        check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_start",     {31'b0, START},     32'd0);
        check("rst_busy",      {31'b0, BUSY},      32'd0);
        check("rst_ab",        {16'b0, A, B},      32'd0);
        check("rst_out",       {15'b0, OUT_ERR, OUT_S}, 32'd0);
        RESET = 1'b0;
        step();

        // 1. Single op: 13*11, latency push->START and START->OUT_VALID.
        OUT_READY = 1'b1;
        push(8'd13, 8'd11, 1'b0);
        wait_for("t1_start", 0, 10, n);
        check("t1_start_latency", n, 32'd2);
        step();
        check("t1_start_pulse", {31'b0, START}, 32'd0);
        check("t1_ab",   {16'b0, A, B}, {16'b0, 8'd13, 8'd11});
        check("t1_busy", {31'b0, BUSY}, 32'd1);
        wait_for("t1_out", 1, 100, n);
        check("t1_out_latency", n, DLY + 1);
        check("t1_out_s",   {16'b0, OUT_S}, 32'd143);
        check("t1_out_err", {31'b0, OUT_ERR}, 32'd0);
        step();
        check("t1_drained", {31'b0, OUT_VALID}, 32'd0);
        check("t1_start_count", start_count, 32'd1);

        // 3 + 2. Backpressure, then a burst that fills the FIFO.
        OUT_READY = 1'b0;
        push(8'd200, 8'd3, 1'b0);
        wait_for("t3_out", 1, 60, n);
        for (int i = 0; i < 5; i++) begin
            IN_VALID = 1'b1;
            IN_A     = ba[i];
            IN_B     = bb[i];
            check("t2_in_ready", {31'b0, IN_READY}, (i < 4) ? 32'd1 : 32'd0);
            if (IN_READY === 1'b1) sb.push_back({1'b0, 16'(ba[i]) * 16'(bb[i])});
            if (i < 4) step();
        end
        for (int i = 0; i < 4; i++) step();
        check("t3_hold_s",      {16'b0, OUT_S},  32'd600);
        check("t3_hold_valid",  {31'b0, OUT_VALID}, 32'd1);
        check("t3_no_start",    start_count, 32'd2);
        check("t2_full",        {31'b0, IN_READY}, 32'd0);
        OUT_READY = 1'b1;
        step();
        check("t3_slot_clear",  {31'b0, OUT_VALID}, 32'd0);
        check("t3_start_h0",    {31'b0, START}, 32'd0);
        step();
        check("t3_start_h1",    {31'b0, START}, 32'd0);
        check("t2_ready_again", {31'b0, IN_READY}, 32'd1);
        if (IN_READY === 1'b1) sb.push_back({1'b0, 16'(ba[4]) * 16'(bb[4])});
        step();
        IN_VALID = 1'b0;
        check("t3_start_h2",    {31'b0, START}, 32'd1);
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check("t2_drain", sb.size(), 32'd0);
        step();

        // 4. Timeout, then the next queued op completes normally.
        stub_hang = 1'b1;
        push(8'd7, 8'd9, 1'b1);
        push(8'd3, 8'd4, 1'b0);
        wait_for("t4_start", 0, 10, n);
        step();
        stub_hang = 1'b0;
        wait_for("t4_out", 1, 100, n);
        check("t4_timeout_latency", n, TO);
        check("t4_err", {31'b0, OUT_ERR}, 32'd1);
        check("t4_s",   {16'b0, OUT_S},   32'd0);
        wait_for("t4_next_start", 0, 10, n);
        check("t4_next_start_latency", n, 32'd3);
        wait_for("t4_next_out", 1, 100, n);
        check("t4_next_latency", n, DLY + 2);
        check("t4_next_err", {31'b0, OUT_ERR}, 32'd0);
        check("t4_next_s",   {16'b0, OUT_S},   32'd12);
        step();

        // 5. END_MULT on the last watchdog cycle wins over the timeout.
        stub_delay = TO - 1;
        push(8'd9, 8'd10, 1'b0);
        wait_for("t5_start", 0, 10, n);
        wait_for("t5_out", 1, 100, n);
        check("t5_latency", n, TO + 1);
        check("t5_err", {31'b0, OUT_ERR}, 32'd0);
        check("t5_s",   {16'b0, OUT_S},   32'd90);
        step();
        stub_delay = DLY;

        // 6. Asynchronous reset mid-WAIT with two ops queued.
        push(8'd5, 8'd5, 1'b0);
        push(8'd6, 8'd6, 1'b0);
        push(8'd7, 8'd7, 1'b0);
        wait_for("t6_start", 0, 10, n);
        for (int i = 0; i < 5; i++) step();
        check("t6_busy_before", {31'b0, BUSY}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("t6_start",     {31'b0, START},     32'd0);
        check("t6_busy",      {31'b0, BUSY},      32'd0);
        check("t6_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("t6_ab",        {16'b0, A, B},      32'd0);
        check("t6_out",       {15'b0, OUT_ERR, OUT_S}, 32'd0);
        check("t6_in_ready",  {31'b0, IN_READY},  32'd1);
        sb.delete();
        sc = start_count;
        step();
        step();
        RESET = 1'b0;
        for (int i = 0; i < 60; i++) step();
        check("t6_no_start",      start_count, sc);
        check("t6_no_result",     {31'b0, OUT_VALID}, 32'd0);
        check("t6_idle",          {31'b0, BUSY}, 32'd0);
        check("t6_ready_after",   {31'b0, IN_READY}, 32'd1);

        // Recovery after reset.
        push(8'd2, 8'd3, 1'b0);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("t6_recover", sb.size(), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
